gemm_tile_sequencer: RTL and testbench
======================================

GEMM_TILE_SEQUENCER -- requirements
Module: gemm_tile_sequencer

Interface
REQ-001 SHALL provide the following ports, each given as name, direction, width and meaning:
- clk, in, 1: the single clock.
- rst, in, 1: reset, asynchronous and active-high.
REQ-002 SHALL provide the configuration-queue ports:
- conf_empty, in, 1: configuration queue has no entry.
- read_all_buffers, out, 1: pop pulse to the configuration queue.
REQ-003 SHALL provide tile_A_addr, tile_B_addr, tile_C_addr, tile_A_stride and tile_B_stride, each in, 32: head-of-queue values, valid whenever conf_empty=0.
REQ-004 SHALL provide msize, ksize and nsize, each in, 5, as head-of-queue tile dimensions; store and overwrite, each in, 1, as head-of-queue GEMM control bits.
REQ-005 SHALL provide the memory request channel:
- mem_valid, out, 1: request valid.
- mem_ready, in, 1: request accepted.
- mem_addr, out, 32: row address.
- mem_we, out, 1: 1 = C row write, 0 = read.
- mem_sel, out, 2: 0 = A, 1 = B, 2 = C.
REQ-006 SHALL provide the array control ports:
- array_start, out, 1: start pulse.
- array_overwrite, out, 1: latched overwrite bit.
- array_done, in, 1: array finished the tile.
REQ-007 SHALL provide the status ports busy, out, 1 (tile in progress) and tile_done, out, 1 (one-cycle pulse at tile completion).

Function
REQ-008 SHALL implement the states IDLE, LOAD_B, LOAD_A, COMPUTE, STORE_C and DONE.
REQ-009 In IDLE with conf_empty=0, SHALL assert read_all_buffers for exactly one cycle, register all head-of-queue inputs on that same edge, and enter LOAD_B.
REQ-010 SHALL never assert read_all_buffers outside IDLE, and never while conf_empty=1.
REQ-011 In LOAD_B, SHALL issue ksize read requests with mem_sel=1:
- address of row i = tile_B_addr + i*tile_B_stride, for i = 0..ksize-1.
- exits to LOAD_A after the last accepted request.
REQ-012 In LOAD_A, SHALL issue msize read requests with mem_sel=0:
- address of row i = tile_A_addr + i*tile_A_stride.
- exits to COMPUTE after the last accepted request.
REQ-013 SHALL treat a request as accepted on a cycle where mem_valid=1 and mem_ready=1.
REQ-014 While mem_valid=1 and mem_ready=0, SHALL hold mem_addr, mem_sel and mem_we stable.
REQ-015 SHALL form addresses with an adder that accumulates the stride on each accepted request (no multiplier), using mod-2^32 wrap-around.
REQ-016 On accept of a row that is not the last row of its phase, SHALL keep mem_valid high, present the next address on the next cycle, and sustain back-to-back issue of one row per cycle.
REQ-017 On entry to COMPUTE, SHALL pulse array_start for one cycle, with array_overwrite equal to the latched overwrite bit.
REQ-018 In COMPUTE, SHALL wait for array_done=1, then go to STORE_C if latched store=1, else to DONE.
REQ-019 In STORE_C, SHALL issue msize write requests with mem_we=1 and mem_sel=2:
- address of row i = tile_C_addr + i*tile_B_stride.
- exits to DONE after the last accepted request.
REQ-020 A size field of 0 SHALL skip its phase with no request issued:
- ksize=0 skips LOAD_B.
- msize=0 skips LOAD_A and STORE_C.
REQ-021 nsize SHALL be latched but SHALL NOT affect the request count.
REQ-022 DONE SHALL last one cycle, pulse tile_done, and return to IDLE.
REQ-023 A new pop SHALL be possible on the cycle after DONE, so a back-to-back tile costs exactly one IDLE cycle.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 SHALL ignore array_done outside COMPUTE.
REQ-026 SHALL ignore mem_ready while mem_valid=0.

Reset
REQ-027 While rst=1, SHALL asynchronously force the state to IDLE and hold every output at 0:
- read_all_buffers, mem_valid, mem_addr, mem_we, mem_sel.
- array_start, array_overwrite, busy, tile_done.
REQ-028 Reset during any state SHALL abandon the tile, with no further requests, no pop, and no tile_done.
REQ-029 After rst falls, SHALL pop no earlier than the first rising edge of clk.

Verification
REQ-030 Full tile:
- Stimulus: A=0x1000, B=0x2000, C=0x3000, strideA=0x40, strideB=0x80, k=2, m=3, store=1, mem_ready=1, array_done 5 cycles after start.
- Required: B reads at 0x2000 and 0x2080; A reads at 0x1000, 0x1040 and 0x1080; one array_start; C writes at 0x3000, 0x3080 and 0x3100; one tile_done; exactly one read_all_buffers.
REQ-031 Backpressure:
- Stimulus: mem_ready low for 3 cycles on the second B row.
- Required: mem_addr stays 0x2080 and mem_valid stays 1 until accepted; total accepted reads are unchanged.
REQ-032 store=0 and zero size:
- Stimulus: store=0, ksize=0, msize=1.
- Required: no B requests, one A request, no C writes, tile_done after array_done.
REQ-033 Queue behaviour:
- Stimulus: two queued configurations.
- Required: two pops, separated by exactly one IDLE cycle after the first tile_done; no pop while conf_empty=1.
REQ-034 Wrap-around:
- Stimulus: B=0xFFFF_FFC0, strideB=0x80, k=2.
- Required: B reads at 0xFFFF_FFC0 and 0x0000_0040.
REQ-035 Reset mid-tile:
- Stimulus: rst asserted mid-LOAD_A.
- Required: all outputs 0 immediately (asynchronously); after release, state IDLE and the next tile starts cleanly.

Source files
------------

// File: rtl/gemm_tile_sequencer.sv
// GEMM tile sequencer: pops one tile configuration and walks the B-load, A-load, compute and
// C-store phases. Row addresses are formed by stride accumulation.
module gemm_tile_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        conf_empty,
   output logic        read_all_buffers,
   input  logic [31:0] tile_A_addr,
   input  logic [31:0] tile_B_addr,
   input  logic [31:0] tile_C_addr,
   input  logic [31:0] tile_A_stride,
   input  logic [31:0] tile_B_stride,
   input  logic [4:0]  msize,
   input  logic [4:0]  ksize,
   input  logic [4:0]  nsize,
   input  logic        store,
   input  logic        overwrite,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [1:0]  mem_sel,
   output logic        array_start,
   output logic        array_overwrite,
   input  logic        array_done,
   output logic        busy,
   output logic        tile_done
);

   typedef enum logic [2:0] {StIdle, StLoadB, StLoadA, StCompute, StStoreC, StDone} state_t;

   state_t      r_state, w_next_state;
   logic [31:0] r_addr, w_next_addr;
   logic [4:0]  r_row, w_next_row;
   logic [31:0] r_a_addr, r_c_addr, r_a_stride, r_b_stride;
   logic [4:0]  r_msize, r_ksize, r_nsize;
   logic        r_store, r_overwrite, r_start;
   logic        w_pop, w_enter_compute, w_mem_phase, w_accept, w_last_row;
   logic [4:0]  w_row_limit;
   logic        w_unused_nsize;

   // nsize only describes the tile to the array; it never changes the request count.
   assign w_unused_nsize = ^r_nsize;

   assign w_mem_phase = (r_state == StLoadB) || (r_state == StLoadA) || (r_state == StStoreC);
   assign w_accept    = w_mem_phase && mem_ready;
   assign w_row_limit = (r_state == StLoadB) ? r_ksize : r_msize;
   assign w_last_row  = (r_row == w_row_limit - 5'd1);

   always_comb begin
      w_next_state    = r_state;
      w_next_addr     = r_addr;
      w_next_row      = r_row;
      w_pop           = 1'b0;
      w_enter_compute = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (!conf_empty) begin
               w_pop      = 1'b1;
               w_next_row = 5'd0;
               // Zero-sized phases are skipped entirely.
               if (ksize != 5'd0) begin
                  w_next_state = StLoadB;
                  w_next_addr  = tile_B_addr;
               end else if (msize != 5'd0) begin
                  w_next_state = StLoadA;
                  w_next_addr  = tile_A_addr;
               end else begin
                  w_next_state    = StCompute;
                  w_enter_compute = 1'b1;
               end
            end
         end
         StLoadB: begin
            if (w_accept) begin
               if (!w_last_row) begin
                  w_next_addr = r_addr + r_b_stride;
                  w_next_row  = r_row + 5'd1;
               end else if (r_msize != 5'd0) begin
                  w_next_state = StLoadA;
                  w_next_addr  = r_a_addr;
                  w_next_row   = 5'd0;
               end else begin
                  w_next_state    = StCompute;
                  w_enter_compute = 1'b1;
               end
            end
         end
         StLoadA: begin
            if (w_accept) begin
               if (!w_last_row) begin
                  w_next_addr = r_addr + r_a_stride;
                  w_next_row  = r_row + 5'd1;
               end else begin
                  w_next_state    = StCompute;
                  w_enter_compute = 1'b1;
               end
            end
         end
         StCompute: begin
            if (array_done) begin
               if (r_store && (r_msize != 5'd0)) begin
                  w_next_state = StStoreC;
                  w_next_addr  = r_c_addr;
                  w_next_row   = 5'd0;
               end else begin
                  w_next_state = StDone;
               end
            end
         end
         StStoreC: begin
            if (w_accept) begin
               if (!w_last_row) begin
                  // C rows share the B stride.
                  w_next_addr = r_addr + r_b_stride;
                  w_next_row  = r_row + 5'd1;
               end else begin
                  w_next_state = StDone;
               end
            end
         end
         StDone:  w_next_state = StIdle;
         default: w_next_state = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_addr      <= 32'd0;
         r_row       <= 5'd0;
         r_a_addr    <= 32'd0;
         r_c_addr    <= 32'd0;
         r_a_stride  <= 32'd0;
         r_b_stride  <= 32'd0;
         r_msize     <= 5'd0;
         r_ksize     <= 5'd0;
         r_nsize     <= 5'd0;
         r_store     <= 1'b0;
         r_overwrite <= 1'b0;
         r_start     <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_addr  <= w_next_addr;
         r_row   <= w_next_row;
         r_start <= w_enter_compute;
         if (w_pop) begin
            r_a_addr    <= tile_A_addr;
            r_c_addr    <= tile_C_addr;
            r_a_stride  <= tile_A_stride;
            r_b_stride  <= tile_B_stride;
            r_msize     <= msize;
            r_ksize     <= ksize;
            r_nsize     <= nsize;
            r_store     <= store;
            r_overwrite <= overwrite;
         end
      end
   end

   // The pop is combinational on conf_empty, so it must be masked while reset is held.
   assign read_all_buffers = w_pop && !rst;
   assign mem_valid        = w_mem_phase;
   assign mem_addr         = w_mem_phase ? r_addr : 32'd0;
   assign mem_we           = (r_state == StStoreC);
   assign mem_sel          = (r_state == StLoadB)  ? 2'd1 :
                             (r_state == StStoreC) ? 2'd2 : 2'd0;
   assign array_start      = r_start;
   assign array_overwrite  = r_overwrite;
   assign busy             = (r_state != StIdle);
   assign tile_done        = (r_state == StDone);

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Bench for gemm_tile_sequencer: directed and random tiles checked against a request-list model
// built from base + row * stride arithmetic.
module tb_gemm_tile_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        conf_empty = 1'b1;
   logic        read_all_buffers;
   logic [31:0] tile_A_addr = '0, tile_B_addr = '0, tile_C_addr = '0;
   logic [31:0] tile_A_stride = '0, tile_B_stride = '0;
   logic [4:0]  msize = '0, ksize = '0, nsize = '0;
   logic        store = 1'b0, overwrite = 1'b0;
   logic        mem_valid, mem_we;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [1:0]  mem_sel;
   logic        array_start, array_overwrite;
   logic        array_done = 1'b0;
   logic        busy, tile_done;

   gemm_tile_sequencer dut (
      .clk(clk), .rst(rst), .conf_empty(conf_empty), .read_all_buffers(read_all_buffers),
      .tile_A_addr(tile_A_addr), .tile_B_addr(tile_B_addr), .tile_C_addr(tile_C_addr),
      .tile_A_stride(tile_A_stride), .tile_B_stride(tile_B_stride),
      .msize(msize), .ksize(ksize), .nsize(nsize), .store(store), .overwrite(overwrite),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_sel(mem_sel), .array_start(array_start), .array_overwrite(array_overwrite),
      .array_done(array_done), .busy(busy), .tile_done(tile_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a, b, c, sa, sb;
      logic [4:0]  k, m, n;
      logic        st, ov;
   } cfg_t;

   cfg_t        cfg_q[$];
   cfg_t        cur_cfg;
   logic [34:0] exp_q[$], obs_q[$];
   logic [34:0] prev_req;
   int          pop_cyc[$], done_cyc[$];
   int          n_cmp = 0, n_bad = 0;
   int          n_pop, n_start, n_done, n_stall, n_bad_pop = 0;
   int          cyc = 0, ad_cyc = -1, wait_cnt = 0, done_delay = 5, ready_pct = 100;
   int          stall_left = 0;
   logic [31:0] stall_addr = '0;
   logic        pop_pending = 1'b0, prev_stall = 1'b0, found;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic cfg_t mk(input logic [31:0] a, b, c, sa, sb, input logic [4:0] k, m,
                               input logic st, ov);
      cfg_t r;
      r.a = a; r.b = b; r.c = c; r.sa = sa; r.sb = sb;
      r.k = k; r.m = m; r.n = 5'($urandom); r.st = st; r.ov = ov;
      return r;
   endfunction

   function automatic cfg_t rnd(input int max_size);
      return mk($urandom, $urandom, $urandom, $urandom, $urandom,
                5'($urandom_range(0, max_size)), 5'($urandom_range(0, max_size)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endfunction

   // Expected request stream: {we, sel, addr} for every row of every phase.
   task automatic push(input cfg_t c);
      cfg_q.push_back(c);
      for (int i = 0; i < int'(c.k); i++) exp_q.push_back({1'b0, 2'd1, 32'(c.b + 32'(i) * c.sb)});
      for (int i = 0; i < int'(c.m); i++) exp_q.push_back({1'b0, 2'd0, 32'(c.a + 32'(i) * c.sa)});
      if (c.st)
         for (int i = 0; i < int'(c.m); i++)
            exp_q.push_back({1'b1, 2'd2, 32'(c.c + 32'(i) * c.sb)});
   endtask

   task automatic drive_conf();
      conf_empty = (cfg_q.size() == 0);
      if (!conf_empty) begin
         tile_A_addr = cfg_q[0].a; tile_B_addr = cfg_q[0].b; tile_C_addr = cfg_q[0].c;
         tile_A_stride = cfg_q[0].sa; tile_B_stride = cfg_q[0].sb;
         ksize = cfg_q[0].k; msize = cfg_q[0].m; nsize = cfg_q[0].n;
         store = cfg_q[0].st; overwrite = cfg_q[0].ov;
      end
   endtask

   task automatic clear();
      obs_q.delete(); exp_q.delete(); pop_cyc.delete(); done_cyc.delete();
      n_pop = 0; n_start = 0; n_done = 0; n_stall = 0;
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      if (pop_pending) begin
         cur_cfg = cfg_q.pop_front();
         pop_pending = 1'b0;
      end
      if (array_start) begin
         wait_cnt = done_delay;
         array_done = 1'b0;
      end else if (wait_cnt > 0) begin
         wait_cnt--;
         array_done = (wait_cnt == 0);
         if (wait_cnt == 0) ad_cyc = cyc;
      end else begin
         // Stray array_done outside the compute window must be ignored.
         array_done = mem_valid && ($urandom_range(0, 3) == 0);
      end
      if (stall_left > 0 && mem_valid && mem_addr == stall_addr) begin
         mem_ready = 1'b0;
         stall_left--;
      end else begin
         mem_ready = ($urandom_range(0, 99) < ready_pct);
      end
      drive_conf();
      #1;
      if (read_all_buffers) begin
         n_pop++;
         pop_cyc.push_back(cyc);
         if (conf_empty || busy) n_bad_pop++;
         pop_pending = 1'b1;
      end
      if (prev_stall)
         check("hold_on_stall", {mem_valid, mem_we, mem_sel, mem_addr}, {1'b1, prev_req});
      if (mem_valid && mem_ready) obs_q.push_back({mem_we, mem_sel, mem_addr});
      if (mem_valid && !mem_ready) n_stall++;
      prev_stall = mem_valid && !mem_ready;
      prev_req   = {mem_we, mem_sel, mem_addr};
      if (array_start) begin
         n_start++;
         check("array_overwrite", array_overwrite, cur_cfg.ov);
      end
      if (tile_done) begin
         n_done++;
         done_cyc.push_back(cyc);
      end
   endtask

   task automatic run_tiles(input string tag, input int target, input int budget);
      int t0 = cyc;
      while (n_done < target && (cyc - t0) < budget) step();
      check({tag, "_tile_done_count"}, n_done, target);
   endtask

   task automatic compare(input string tag);
      check({tag, "_req_count"}, obs_q.size(), exp_q.size());
      foreach (exp_q[i])
         if (i < obs_q.size()) check($sformatf("%s_req%0d", tag, i), obs_q[i], exp_q[i]);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pop"}, read_all_buffers, 0);
      check({tag, "_mem_valid"}, mem_valid, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_sel"}, mem_sel, 0);
      check({tag, "_array_start"}, array_start, 0);
      check({tag, "_array_overwrite"}, array_overwrite, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_tile_done"}, tile_done, 0);
   endtask

   initial begin
      cfg_t full, c;

      repeat (2) @(posedge clk);
      #2;
      check_outputs_zero("reset");
      rst = 1'b0;

      // Full tile with fixed addresses.
      clear();
      full = mk(32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h80, 5'd2, 5'd3, 1'b1, 1'b1);
      push(full);
      run_tiles("full", 1, 200);
      compare("full");
      check("full_pops", n_pop, 1);
      check("full_starts", n_start, 1);

      // Backpressure on the second B row.
      clear();
      full.ov = 1'b0;
      push(full);
      stall_addr = 32'h2080;
      stall_left = 3;
      run_tiles("bp", 1, 200);
      compare("bp");
      check("bp_stall_cycles", n_stall, 3);
      check("bp_stall_consumed", stall_left, 0);

      // store=0 with ksize=0: one A read, done right after array_done.
      clear();
      done_delay = 3;
      c = rnd(3);
      c.k = 5'd0; c.m = 5'd1; c.st = 1'b0;
      push(c);
      run_tiles("nostore", 1, 200);
      compare("nostore");
      if (done_cyc.size() > 0) check("nostore_done_after_array_done", done_cyc[0], ad_cyc + 1);

      // Two queued configurations: exactly one IDLE cycle between tiles.
      clear();
      ready_pct = 70;
      push(rnd(4));
      push(rnd(4));
      run_tiles("queue", 2, 400);
      compare("queue");
      check("queue_pops", n_pop, 2);
      if (pop_cyc.size() == 2 && done_cyc.size() == 2)
         check("queue_pop_gap", pop_cyc[1], done_cyc[0] + 1);

      // 32-bit wrap of the B address.
      clear();
      ready_pct = 100;
      c = rnd(3);
      c.b = 32'hFFFF_FFC0; c.sb = 32'h80; c.k = 5'd2;
      push(c);
      run_tiles("wrap", 1, 200);
      compare("wrap");

      // Reset in the middle of LOAD_A, with a new entry queued while reset is held.
      clear();
      push(mk($urandom, $urandom, $urandom, $urandom, $urandom, 5'd1, 5'd4, 1'b1, 1'b1));
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         step();
         found = mem_valid && (mem_sel == 2'd0);
      end
      check("rst_reached_load_a", found, 1);
      #1 rst = 1'b1;
      #1 check_outputs_zero("rst_async");
      clear();
      cfg_q.delete();
      pop_pending = 1'b0;
      wait_cnt = 0;
      prev_stall = 1'b0;
      array_done = 1'b0;
      c = rnd(4);
      c.k = 5'd2; c.m = 5'd2;
      push(c);
      drive_conf();
      @(posedge clk);
      @(posedge clk);
      #2 check_outputs_zero("rst_held");
      #1 rst = 1'b0;
      #1;
      check("rst_release_busy", busy, 0);
      check("rst_release_pop_ready", read_all_buffers, 1);
      if (read_all_buffers) begin
         n_pop++;
         pop_cyc.push_back(cyc);
         pop_pending = 1'b1;
      end
      run_tiles("after_rst", 1, 200);
      compare("after_rst");
      check("after_rst_pops", n_pop, 1);
      check("after_rst_starts", n_start, 1);

      // Random back-to-back tiles under random backpressure.
      clear();
      ready_pct = 60;
      done_delay = $urandom_range(1, 4);
      for (int i = 0; i < 6; i++) push(rnd(5));
      run_tiles("rand", 6, 3000);
      compare("rand");
      check("rand_pops", n_pop, 6);
      check("rand_starts", n_start, 6);
      for (int i = 1; i < 6; i++)
         if (i < pop_cyc.size() && i <= done_cyc.size())
            check($sformatf("rand_pop_gap%0d", i), pop_cyc[i], done_cyc[i-1] + 1);

      repeat (3) step();
      check("illegal_pops", n_bad_pop, 0);
      check("idle_at_end", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
